uart_ram_loader: RTL
====================

Name: uart_ram_loader

Overview:
Command sequencer between the UART byte stream and the UART-side port (port a) of the shared dual-port activation/weight RAM.
- Parses host frames.
- Writes bursts into RAM and reads bursts back out over UART TX.
- Launches the CNN core and acknowledges its completion.

The only master of port a; the CNN core keeps port b.

Parameters:
ADDR_W, 8, RAM address width (1..8); host address byte truncated to low ADDR_W bits
DATA_W, 8, RAM word width; fixed equal to UART byte width (8)

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  asynchronous, active-high reset
rx_valid  in  1  one-cycle strobe, rx_data holds a received byte
rx_data  in  8  received UART byte
tx_valid  out  1  byte to transmit is valid
tx_data  out  8  byte to transmit
tx_ready  in  1  UART TX accepts byte when tx_valid && tx_ready
ram_we  out  1  port a write enable
ram_addr  out  ADDR_W  port a address
ram_wdata  out  DATA_W  port a write data
ram_rdata  in  DATA_W  port a read data, valid one cycle after ram_addr presented (registered read)
cnn_start  out  1  one-cycle pulse launching CNN core
cnn_done  in  1  CNN completion strobe
busy  out  1  high in any state other than IDLE
err  out  1  one-cycle pulse on protocol error

Behaviour:
- Reset: all outputs 0, state IDLE, addr and len counters 0.
- Frame format: CMD, then for WR/RD: ADDR byte, LEN byte, then payload.
  - CMD 0xA5 = write; 0x5A = read; 0xC3 = run.
- Transitions:
  - IDLE: on rx_valid with 0xA5 or 0x5A -> GET_ADDR (latch cmd); 0xC3 -> RUN (cnn_start=1 next cycle, exactly one cycle); any other byte -> err pulse, stay IDLE.
  - GET_ADDR: on rx_valid, latch addr -> GET_LEN.
  - GET_LEN: on rx_valid:
    - LEN==0 -> err pulse, IDLE.
    - Else latch count=LEN; write -> WR_DATA, read -> RD_ISSUE.
- WR_DATA write path:
  - Each rx_valid produces ram_we=1, ram_addr=addr, ram_wdata=rx_data on the following cycle (single-cycle pulse).
  - Then addr+1 modulo 2^ADDR_W and count-1.
  - Count reaching 0 -> IDLE in the same cycle as the last write pulse.
- Read path:
  - RD_ISSUE: drive ram_addr=addr (we=0) -> RD_WAIT.
  - RD_WAIT: capture ram_rdata into tx_data, tx_valid=1 -> RD_SEND.
  - RD_SEND: hold tx_valid/tx_data stable until tx_ready; on handshake tx_valid=0, addr+1 (wrap), count-1; count 0 -> IDLE, else RD_ISSUE.
- Run path:
  - RUN: wait for cnn_done -> ACK.
  - ACK: tx_valid=1, tx_data=0xD0 until tx_ready -> IDLE.
  - cnn_done outside RUN is ignored.
- Throughput: read burst at most 1 byte per 3 cycles when tx_ready is held high. Write burst accepts rx_valid every cycle.
- rx_valid in RD_ISSUE/RD_WAIT/RD_SEND/RUN/ACK: byte dropped, err pulse, current operation continues.
- Address wrap: addr 2^ADDR_W-1 increments to 0; no error.
- Simultaneous cnn_done and the cnn_start cycle: done is honoured (RUN is entered the cycle start is pulsed).
- rst mid-frame: immediate return to IDLE, ram_we and tx_valid drop asynchronously, partial burst not completed, no ack.
- ram_we is never asserted outside WR_DATA-induced pulses.
- tx_valid never drops without a handshake except on reset.

Test Plan:
- Write A5,10,03,11,22,33 -> ram_we pulses with (0x10,0x11),(0x11,0x22),(0x12,0x33); busy back to 0 after third pulse.
- Read 5A,10,03 with RAM model preloaded and tx_ready toggling 1-of-2 cycles -> tx bytes 11,22,33 in order, tx_data stable while tx_valid && !tx_ready.
- Wrap: write A5,FF,02,AA,BB -> writes to 0xFF then 0x00.
- Run: C3 -> single cnn_start pulse; cnn_done after 50 cycles -> tx 0xD0, busy 0 after handshake; extra rx byte during RUN -> err pulse, ack still sent.
- Errors: byte 0x77 in IDLE -> err pulse, no RAM access; A5,00,00 -> err pulse at LEN, IDLE.
- Reset during write burst after 1 of 3 bytes -> ram_we=0 immediately, busy 0; next frame A5,20,01,44 processed normally.

Source files
------------

// File: rtl/uart_ram_loader.sv
// Host command sequencer: parses UART frames into RAM port-a write/read bursts and CNN run
// requests, returning read data and a run acknowledge over UART TX.
module uart_ram_loader #(
   parameter int unsigned ADDR_W = 8,
   parameter int unsigned DATA_W = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              rx_valid,
   input  logic [7:0]        rx_data,
   output logic              tx_valid,
   output logic [7:0]        tx_data,
   input  logic              tx_ready,
   output logic              ram_we,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [DATA_W-1:0] ram_wdata,
   input  logic [DATA_W-1:0] ram_rdata,
   output logic              cnn_start,
   input  logic              cnn_done,
   output logic              busy,
   output logic              err
);

   localparam logic [7:0] CmdWrite = 8'hA5;
   localparam logic [7:0] CmdRead  = 8'h5A;
   localparam logic [7:0] CmdRun   = 8'hC3;
   localparam logic [7:0] AckByte  = 8'hD0;

   typedef enum logic [3:0] {
      StIdle, StGetAddr, StGetLen, StWrData, StRdIssue, StRdWait, StRdSend, StRun, StAck
   } state_e;

   state_e            state_q, state_d;
   logic              is_rd_q, is_rd_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [7:0]        count_q, count_d;
   logic              we_q, we_d;
   logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic              tx_valid_q, tx_valid_d;
   logic [7:0]        tx_data_q, tx_data_d;
   logic              start_q, start_d;
   logic              err_q, err_d;

   always_comb begin
      state_d    = state_q;
      is_rd_d    = is_rd_q;
      addr_d     = addr_q;
      count_d    = count_q;
      we_d       = 1'b0;
      wr_addr_d  = wr_addr_q;
      wdata_d    = wdata_q;
      tx_valid_d = tx_valid_q;
      tx_data_d  = tx_data_q;
      start_d    = 1'b0;
      err_d      = 1'b0;

      unique case (state_q)
         StIdle: begin
            if (rx_valid) begin
               if (rx_data == CmdWrite || rx_data == CmdRead) begin
                  is_rd_d = (rx_data == CmdRead);
                  state_d = StGetAddr;
               end else if (rx_data == CmdRun) begin
                  start_d = 1'b1;
                  state_d = StRun;
               end else begin
                  err_d = 1'b1;
               end
            end
         end
         StGetAddr: begin
            if (rx_valid) begin
               addr_d  = rx_data[ADDR_W-1:0];
               state_d = StGetLen;
            end
         end
         StGetLen: begin
            if (rx_valid) begin
               if (rx_data == 8'h00) begin
                  err_d   = 1'b1;
                  state_d = StIdle;
               end else begin
                  count_d = rx_data;
                  state_d = is_rd_q ? StRdIssue : StWrData;
               end
            end
         end
         StWrData: begin
            // Registered write pulse lands the cycle after the byte arrives.
            if (rx_valid) begin
               we_d      = 1'b1;
               wr_addr_d = addr_q;
               wdata_d   = rx_data;
               addr_d    = addr_q + ADDR_W'(1);
               count_d   = count_q - 8'd1;
               if (count_q == 8'd1) state_d = StIdle;
            end
         end
         StRdIssue: state_d = StRdWait;
         StRdWait: begin
            tx_data_d  = ram_rdata;
            tx_valid_d = 1'b1;
            state_d    = StRdSend;
         end
         StRdSend: begin
            if (tx_ready) begin
               tx_valid_d = 1'b0;
               addr_d     = addr_q + ADDR_W'(1);
               count_d    = count_q - 8'd1;
               state_d    = (count_q == 8'd1) ? StIdle : StRdIssue;
            end
         end
         StRun: begin
            if (cnn_done) begin
               tx_valid_d = 1'b1;
               tx_data_d  = AckByte;
               state_d    = StAck;
            end
         end
         StAck: begin
            if (tx_ready) begin
               tx_valid_d = 1'b0;
               state_d    = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase

      // Bytes arriving while reading or running are dropped and flagged.
      if (rx_valid && (state_q == StRdIssue || state_q == StRdWait || state_q == StRdSend ||
                       state_q == StRun || state_q == StAck)) begin
         err_d = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= StIdle;
         is_rd_q    <= 1'b0;
         addr_q     <= '0;
         count_q    <= '0;
         we_q       <= 1'b0;
         wr_addr_q  <= '0;
         wdata_q    <= '0;
         tx_valid_q <= 1'b0;
         tx_data_q  <= '0;
         start_q    <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         is_rd_q    <= is_rd_d;
         addr_q     <= addr_d;
         count_q    <= count_d;
         we_q       <= we_d;
         wr_addr_q  <= wr_addr_d;
         wdata_q    <= wdata_d;
         tx_valid_q <= tx_valid_d;
         tx_data_q  <= tx_data_d;
         start_q    <= start_d;
         err_q      <= err_d;
      end
   end

   assign ram_we    = we_q;
   assign ram_addr  = (state_q == StRdIssue) ? addr_q : wr_addr_q;
   assign ram_wdata = wdata_q;
   assign tx_valid  = tx_valid_q;
   assign tx_data   = tx_data_q;
   assign cnn_start = start_q;
   assign err       = err_q;
   assign busy      = (state_q != StIdle);

endmodule
